// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder built on one 4-bit ripple-carry adder, one nibble per clock, LSB first.
// Optional signed-overflow output is enabled by defining NSA_OVF_EN.

module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   c_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   c_out,
  output logic                   busy
`ifdef NSA_OVF_EN
  ,
  output logic                   ovf
`endif
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state_q;
  logic [W-1:0]    a_q, b_q, work_q, work_d, sum_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q, c_out_q;
  logic            in_ready_q, out_valid_q, busy_q;
  logic [3:0]      a_nib [NIBBLES];
  logic [3:0]      b_nib [NIBBLES];
  logic [3:0]      rca_sum;
  logic            rca_cout;

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_q[gi*4 +: 4];
      assign b_nib[gi] = b_q[gi*4 +: 4];
      // Work register with the current nibble already merged in, so the final edge sees the full result.
      assign work_d[gi*4 +: 4] = (idx_q == IW'(gi)) ? rca_sum : work_q[gi*4 +: 4];
    end
  endgenerate

  rca u_rca (
    .a     (a_nib[idx_q]),
    .b     (b_nib[idx_q]),
    .c_in  (carry_q),
    .sum   (rca_sum),
    .c_out (rca_cout)
  );

`ifdef NSA_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == ADD && idx_q == LAST_IDX) begin
      ovf_q <= rca_cout ^ (a_q[W-1] ^ b_q[W-1] ^ work_d[W-1]);
    end
  end
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      work_q      <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= c_in;
            idx_q      <= '0;
            state_q    <= ADD;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ADD: begin
          work_q  <= work_d;
          carry_q <= rca_cout;
          idx_q   <= idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            sum_q       <= work_d;
            c_out_q     <= rca_cout;
            idx_q       <= '0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder (NIBBLES=4): vector table, scoreboard queue and handshake/reset sequences.

module tb_nibble_serial_adder;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;
`ifdef NSA_OVF_EN
  logic         ovf;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  vec_t vecs[10];
  vec_t sb[$];

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
`ifdef NSA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send(input vec_t v, input bit push, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a = v.a;
    b = v.b;
    c_in = v.cin;
    in_valid = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    if (push) sb.push_back(v);
    @(negedge clk);
    in_valid = 1'b0;
    $display("[TB] accept a=0x%04h b=0x%04h cin=%0d at cycle %0d", v.a, v.b, v.cin, acc);
  endtask

  task automatic check_result(input string tag);
    vec_t v;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      v = sb.pop_front();
      chk({tag, "_sum"}, {16'd0, sum}, {16'd0, v.sum});
      chk({tag, "_cout"}, {31'd0, c_out}, {31'd0, v.cout});
`ifdef NSA_OVF_EN
      chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
`endif
      $display("[TB] result a=0x%04h b=0x%04h cin=%0d -> sum=0x%04h c_out=%0d", v.a, v.b, v.cin, sum, c_out);
    end
  endtask

  task automatic recv(input int acc, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_latency"}, cyc - acc, NIBBLES);
    check_result(tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int acc, acc2, n, hits;
    vec_t v;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
    vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[8] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, c_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      send(vecs[i], 1'b1, acc);
      recv(acc, $sformatf("vec%0d", i));
    end

    // Result holds through IDLE, then async reset clears it mid-cycle
    @(negedge clk);
    chk("hold_sum_idle", {16'd0, sum}, 32'h1000);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_sum", {16'd0, sum}, 32'd0);
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Carry register stays 1 and each written nibble is 0 for FFFF+0000+1
    send(vecs[0], 1'b1, acc);
    recv(acc, "pre_carry");
    send(vecs[1], 1'b1, acc);
    chk("carry_latched", {31'd0, dut.carry_q}, 32'd1);
    for (int k = 0; k < NIBBLES; k++) begin
      @(negedge clk);
      chk($sformatf("work_nib%0d", k), {28'd0, dut.work_q[k*4 +: 4]}, 32'd0);
      chk($sformatf("carry_add%0d", k), {31'd0, dut.carry_q}, 32'd1);
      if (k < NIBBLES - 1) chk($sformatf("busy_add%0d", k), {31'd0, busy}, 32'd1);
    end
    recv(acc, "carry_seq");

    // Backpressure with competing in_valid while DONE
    send(vecs[0], 1'b1, acc);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check_result("bp");
    a = 16'h0001;
    b = 16'h0000;
    c_in = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_sum", {16'd0, sum}, 32'h5555);
      chk("bp_hold_cout", {31'd0, c_out}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_no_capture", {16'd0, dut.a_q}, 32'h1234);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_idle_ov", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1 acc2 = cyc;
    v = '{16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0};
    sb.push_back(v);
    chk("bp_throughput", {31'd0, (acc2 - acc) >= NIBBLES + 2}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    recv(acc2, "bp_next");

    // Reset during the 2nd ADD cycle abandons the operation
    v = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    send(v, 1'b0, acc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midadd_busy", {31'd0, busy}, 32'd0);
    chk("midadd_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk("midadd_no_valid", hits, 0);
    send(vecs[2], 1'b1, acc);
    recv(acc, "after_rst");

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle N-nibble adder that sits directly upstream of the 4-bit ripple-carry adder `rca` (ports a, b, c_in, sum, c_out). It accepts wide operands over a valid/ready handshake and feeds them to a single `rca` instance one nibble per clock, least-significant nibble first. It chains the carry through a register and presents the assembled wide result on an output valid/ready handshake. This is how the team reuses the 4-bit adder for 8/16/32-bit sums without replicating it.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..8.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands present.
- `in_ready` output 1: block can accept operands.
- `a` input W: operand A.
- `b` input W: operand B.
- `c_in` input 1: carry into nibble 0.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer takes result.
- `sum` output W: registered result.
- `c_out` output 1: registered carry out of the top nibble.
- `busy` output 1: high in ADD or DONE.
- `ovf` output 1: signed overflow; exists only with `NSA_OVF_EN`.

## Operation
- One `rca` instance. Its inputs are the selected nibble of the latched A, the selected nibble of the latched B, and the carry register.
- FSM states: IDLE, ADD, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`:
  - latch `a` and `b`;
  - carry register <= `c_in`;
  - nibble index <= 0;
  - go to ADD.
- ADD: each cycle:
  - write `rca.sum` into work-register nibble[index];
  - carry register <= `rca.c_out`;
  - index increments.
- When index == NIBBLES-1, that same edge also:
  - loads `sum` from the completed work register;
  - loads `c_out` from the final `rca.c_out`;
  - goes to DONE.
- DONE: `out_valid`=1. On `out_ready` go to IDLE.
- Arithmetic: {`c_out`,`sum`} = `a` + `b` + `c_in`, exact and unsigned, (W+1) bits. There is no truncation except the split into `c_out` and `sum`.
- `in_ready` is high only in IDLE. `in_valid` in ADD/DONE is ignored and no operand is captured.
- `sum` and `c_out` change only on the ADD->DONE edge. They hold the last result through IDLE until the next completion.
- `busy` = (state != IDLE).

## Timing
- Reset values, applied asynchronously on `rst_n`=0:
  - state IDLE;
  - `in_ready` 1;
  - `out_valid` 0;
  - `busy` 0;
  - `sum` 0;
  - `c_out` 0;
  - `ovf` 0;
  - index 0;
  - carry register 0.
- Release of `rst_n` is taken synchronously to `clk`.
- Latency: operands accepted at edge E0; `out_valid` rises after edge E(NIBBLES), i.e. NIBBLES cycles later.
- Throughput: at most one operation per NIBBLES+2 cycles. The output handshake costs 1 edge and the return to IDLE costs 1 edge.
- Handshakes:
  - a transfer occurs on a rising edge where valid & ready are both high;
  - `out_valid`, once high, stays high with `sum`/`c_out` stable until `out_ready` is sampled high;
  - `in_ready` does not depend combinationally on `in_valid`.
- Reset mid-ADD or mid-DONE: the operation is abandoned, `out_valid` never asserts for it, and the next accepted operation is unaffected.
- Carry wrap: a carry out of nibble k is consumed by nibble k+1 exactly one cycle later. Only the carry out of nibble NIBBLES-1 reaches `c_out`.

## Configuration
- `NSA_OVF_EN` defined:
  - port `ovf` exists;
  - `ovf` is loaded on the ADD->DONE edge with (final carry out) XOR (carry into the MSB), where carry into the MSB = `a`[W-1]^`b`[W-1]^`sum`[W-1];
  - `ovf` holds with `sum` and resets to 0.
- `NSA_OVF_EN` undefined: no `ovf` port and no related logic. All other behaviour is identical.

## Test plan
- Reset with `rst_n`=0 mid-cycle: `in_ready`=1, `out_valid`=0, `busy`=0, `sum`=0x0000, `c_out`=0 immediately, without waiting for a clock edge.
- NIBBLES=4, a=0x1234, b=0x4321, c_in=0, accepted at E0: `out_valid` high exactly after E4, sum=0x5555, c_out=0.
- a=0xFFFF, b=0x0000, c_in=1: sum=0x0000, c_out=1. Work-register nibbles read 0 each ADD cycle and the carry register stays 1 through all four cycles.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` and drive a new in_valid with a=0x0001 meanwhile:
  - `sum`/`c_out` stay stable;
  - `in_ready`=0 and the new operands are not captured;
  - after `out_ready`=1, IDLE is reached one edge later and the next accept happens no earlier than NIBBLES+2 cycles after the previous one.
- Assert `rst_n`=0 during the 2nd ADD cycle of a=0xAAAA + b=0x5555: `out_valid` never rises for it. A following a=0x0F0F + b=0x00F1, c_in=0 yields sum=0x1000, c_out=0.
- With `NSA_OVF_EN`:
  - 0x7FFF+0x0001 gives sum=0x8000, c_out=0, ovf=1;
  - 0xFFFF+0x0001 gives sum=0x0000, c_out=1, ovf=0.
  - Without the macro, the same bench compiles with the `ovf` checks removed and produces identical sum/c_out.
